// File: rtl/radixn_serial_adder_if.sv
// radixn_serial_adder_if
//   Operand/result bundle for the digit-serial radix-N adder/subtractor.
//   master : operand source (switch/operand registers) - drives start,
//            mode, inA, inB, Cin; observes busy, done, out0, out1, err.
//   slave  : the adder itself - the mirror image of master.
//   Digit i of any multi-digit bus lives at [i*W +: W], W = $clog2(RADIX).
interface radixn_serial_adder_if #(
    parameter int RADIX  = 9,
    parameter int DIGITS = 4
);
    localparam int W = $clog2(RADIX);

    logic                start;
    logic                mode;
    logic [DIGITS*W-1:0] inA;
    logic [DIGITS*W-1:0] inB;
    logic                Cin;
    logic                busy;
    logic                done;
    logic [DIGITS*W-1:0] out0;
    logic                out1;
    logic                err;

    modport master (
        output start, mode, inA, inB, Cin,
        input  busy, done, out0, out1, err
    );

    modport slave (
        input  start, mode, inA, inB, Cin,
        output busy, done, out0, out1, err
    );
endinterface

// File: rtl/radixn_serial_adder.sv
// radixn_serial_adder
//   Digit-serial adder/subtractor, one digit per clock, LSD first.
//   Add:      out0 = A + B + Cin, out1 = carry-out.
//   Subtract: out0 = A - B - Cin (radix-complement wrapped),
//             out1 = borrow-out (1 when A < B + Cin).
//   Operands holding a digit >= RADIX raise err and force a zero result.
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset, overrides everything
//   bus : slave side of radixn_serial_adder_if
//         start/mode/inA/inB/Cin sampled on an accepted start (IDLE/DONE),
//         busy high during RUN, done a one-cycle pulse in DONE,
//         out0/out1/err held until the next accepted start.
module radixn_serial_adder #(
    parameter int RADIX  = 9,
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    radixn_serial_adder_if.slave bus
);
    localparam int W     = $clog2(RADIX);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [W:0]       RAD_EXT  = (W+1)'(RADIX);
    localparam logic [W-1:0]     RAD_M1   = W'(RADIX - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [DIGITS*W-1:0] a_sh;
    logic [DIGITS*W-1:0] b_sh;
    logic                mode_q;
    logic                c_q;
    logic [IDX_W-1:0]    idx;
    logic [DIGITS*W-1:0] out0_q;
    logic                out1_q;
    logic                err_q;

    logic                accept;
    logic                err_in;
    logic [W-1:0]        a_d;
    logic [W-1:0]        b_d;
    logic [W-1:0]        b_eff;
    logic [W:0]          sum;
    logic [W:0]          sum_wrap;
    logic                c_nxt;
    logic [W-1:0]        dig;

    // start is only honoured outside RUN; no queueing.
    assign accept = bus.start && (state != RUN);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN:  if (idx == LAST_IDX) state_nxt = DONE;
            DONE: state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
        bus.out0 = out0_q;
        bus.out1 = out1_q;
        bus.err  = err_q;
    end

    // ------------------------------------------------------------------
    // Illegal-digit detection over both incoming operands.
    // Compared in W+1 bits so RADIX = 2**W never flags.
    // ------------------------------------------------------------------
    always_comb begin
        err_in = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ({1'b0, bus.inA[i*W +: W]} >= RAD_EXT) err_in = 1'b1;
            if ({1'b0, bus.inB[i*W +: W]} >= RAD_EXT) err_in = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit datapath. Operands are shifted right each RUN cycle so the
    // current digit always sits in the low field.
    // ------------------------------------------------------------------
    always_comb begin
        a_d      = a_sh[W-1:0];
        b_d      = b_sh[W-1:0];
        b_eff    = mode_q ? (RAD_M1 - b_d) : b_d;
        sum      = {1'b0, a_d} + {1'b0, b_eff} + {{W{1'b0}}, c_q};
        sum_wrap = sum - RAD_EXT;
        c_nxt    = (sum >= RAD_EXT);
        dig      = c_nxt ? sum_wrap[W-1:0] : sum[W-1:0];
    end

    // ------------------------------------------------------------------
    // Operand latch, running carry, digit index and result registers.
    // Subtract is A + (RADIX-1-B) + ~Cin; the final carry is inverted to
    // report a borrow.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            mode_q <= 1'b0;
            c_q    <= 1'b0;
            idx    <= '0;
            out0_q <= '0;
            out1_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            a_sh   <= bus.inA;
            b_sh   <= bus.inB;
            mode_q <= bus.mode;
            c_q    <= bus.mode ? ~bus.Cin : bus.Cin;
            idx    <= '0;
            out0_q <= '0;
            out1_q <= 1'b0;
            err_q  <= err_in;
        end else if (state == RUN) begin
            a_sh <= a_sh >> W;
            b_sh <= b_sh >> W;
            c_q  <= c_nxt;
            idx  <= idx + 1'b1;
            // With err set the fields stay at the zero written on start.
            if (!err_q) begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx == IDX_W'(i)) out0_q[i*W +: W] <= dig;
                end
            end
            if (idx == LAST_IDX) begin
                out1_q <= err_q ? 1'b0 : (mode_q ? ~c_nxt : c_nxt);
            end
        end
    end
endmodule
